// File: rtl/encout_apb_ctl.sv
// APB3 slave front-end for the encoder register block: one-hot strobes, fixed 4-cycle transfers.
// Optional macro ENCOUT_APB_PSLVERR_EN enables o_pslverr reporting; without it o_pslverr is tied to 0.
module encout_apb_ctl #(
  parameter int NUM_REG    = 9,
  parameter int VER_IDX    = 8,
  parameter int STATUS_IDX = 7
) (
  input  logic               i_pclk,
  input  logic               i_preset,
  input  logic               i_psel,
  input  logic               i_penable,
  input  logic               i_pwrite,
  input  logic [7:0]         i_paddr,
  input  logic [31:0]        i_pwdata,
  output logic [31:0]        o_prdata,
  output logic               o_pready,
  output logic               o_pslverr,
  output logic [NUM_REG-1:0] o_we,
  output logic [NUM_REG-1:0] o_re,
  output logic [31:0]        o_wdata,
  input  logic [31:0]        i_rdata,
  input  logic               i_reg_str,
  input  logic               i_reg_opt
);

  typedef enum logic [1:0] {IDLE, STRB, WAIT, DONE} state_e;

  localparam logic [6:0]         NUM_REG_W = 7'(NUM_REG);
  localparam logic [5:0]         VER_I     = 6'(VER_IDX);
  localparam logic [5:0]         STATUS_I  = 6'(STATUS_IDX);
  localparam logic [NUM_REG-1:0] ONE_HOT0  = {{(NUM_REG-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [5:0]           idx_q, idx_d;
  logic                 write_q, write_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [NUM_REG-1:0]   we_q, we_d, re_q, re_d;
  logic [31:0]          prdata_q, prdata_d;
  logic                 pready_q, pready_d;
  logic [5:0]           setup_idx;
  logic                 setup_mapped, setup_ro, cap_mapped;
`ifdef ENCOUT_APB_PSLVERR_EN
  logic                 err_q, err_d;
  logic                 pslverr_q, pslverr_d;
  logic                 cap_ro, str_guarded;
`else
  logic                 unused_cfg;
  assign unused_cfg = i_reg_str ^ i_reg_opt;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d  = state_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    we_d     = '0;
    re_d     = '0;
    prdata_d = prdata_q;
    pready_d = 1'b0;

    setup_idx    = i_paddr[7:2];
    setup_mapped = {1'b0, setup_idx} < NUM_REG_W;
    setup_ro     = (setup_idx == STATUS_I) || (setup_idx == VER_I);
    cap_mapped   = {1'b0, idx_q} < NUM_REG_W;
`ifdef ENCOUT_APB_PSLVERR_EN
    err_d       = err_q;
    pslverr_d   = pslverr_q;
    cap_ro      = (idx_q == STATUS_I) || (idx_q == VER_I);
    str_guarded = (idx_q == 6'd0) || (idx_q == 6'd2) || (idx_q == 6'd3) ||
                  (idx_q == 6'd5) || (idx_q == 6'd6);
`endif

    case (state_q)
      IDLE: begin
        if (i_psel && !i_penable) begin
          state_d = STRB;
          idx_d   = setup_idx;
          write_d = i_pwrite;
          wdata_d = i_pwdata;
          // The strobe is registered here so it is high for the whole STRB cycle.
          if (setup_mapped && !(i_pwrite && setup_ro)) begin
            if (i_pwrite) we_d = ONE_HOT0 << setup_idx;
            else          re_d = ONE_HOT0 << setup_idx;
          end
        end
      end
      STRB: begin
        state_d = WAIT;
`ifdef ENCOUT_APB_PSLVERR_EN
        err_d = !cap_mapped ||
                (write_q && (cap_ro || (i_reg_str && str_guarded) ||
                             (i_reg_opt && (idx_q == 6'd5))));
`endif
      end
      WAIT: begin
        state_d  = DONE;
        pready_d = 1'b1;
        prdata_d = (cap_mapped && !write_q) ? i_rdata : 32'd0;
`ifdef ENCOUT_APB_PSLVERR_EN
        pslverr_d = err_q;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it is sampled only inside the clocked block.
  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      we_q      <= '0;
      re_q      <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
`ifdef ENCOUT_APB_PSLVERR_EN
      err_q     <= 1'b0;
      pslverr_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      state_q   <= state_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
`ifdef ENCOUT_APB_PSLVERR_EN
      err_q     <= err_d;
      pslverr_q <= pslverr_d;
`endif
    end
  end

  assign o_we     = we_q;
  assign o_re     = re_q;
  assign o_wdata  = wdata_q;
  assign o_prdata = prdata_q;
  assign o_pready = pready_q;
`ifdef ENCOUT_APB_PSLVERR_EN
  assign o_pslverr = pslverr_q;
`else
  assign o_pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_encout_apb_ctl.sv
// Self-checking bench for encout_apb_ctl: directed cases plus randomized transfers
// checked against a rule-level reference model.
module tb_encout_apb_ctl;
  localparam int NUM_REG = 9;
`ifdef ENCOUT_APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               preset = 1'b1;
  logic               psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]         paddr = '0;
  logic [31:0]        pwdata = '0, rdata = '0;
  logic               reg_str = 1'b0, reg_opt = 1'b0;
  logic [31:0]        prdata, wdata;
  logic               pready, pslverr;
  logic [NUM_REG-1:0] we, re;

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_prdata = '0;
  logic        last_err = 1'b0;

  encout_apb_ctl dut (
    .i_pclk(clk), .i_preset(preset), .i_psel(psel), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata),
    .o_pready(pready), .o_pslverr(pslverr), .o_we(we), .o_re(re),
    .o_wdata(wdata), .i_rdata(rdata), .i_reg_str(reg_str), .i_reg_opt(reg_opt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One APB transfer; setup in cycle 0, checks in cycles 1..3 at the falling edge.
  task automatic xfer(input string tag, input logic [7:0] addr, input bit wr,
                      input logic [31:0] wd, input bit str, input bit opt,
                      input logic [31:0] rd, input bit noise);
    int          idx;
    bit          mapped, ro, err;
    logic [31:0] stb, exp_we, exp_re, exp_prd;
    idx     = int'(addr[7:2]);
    mapped  = idx < NUM_REG;
    ro      = (idx == 7) || (idx == 8);
    stb     = (mapped && !(wr && ro)) ? (32'd1 << idx) : 32'd0;
    exp_we  = wr ? stb : 32'd0;
    exp_re  = wr ? 32'd0 : stb;
    err     = !mapped || (wr && (ro || (str && (idx inside {0, 2, 3, 5, 6})) ||
                                 (opt && idx == 5)));
    exp_prd = (!wr && mapped) ? rd : 32'd0;

    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
    reg_str = str; reg_opt = opt; rdata = $urandom;

    @(negedge clk);
    check({tag, ".c1_we"}, 32'(we), exp_we);
    check({tag, ".c1_re"}, 32'(re), exp_re);
    check({tag, ".c1_wdata"}, wdata, wd);
    check({tag, ".c1_pready"}, 32'(pready), 32'd0);
    check({tag, ".c1_prdata_hold"}, prdata, last_prdata);
    check({tag, ".c1_pslverr_hold"}, 32'(pslverr), 32'(last_err));
    penable = 1'b1; rdata = $urandom;
    if (noise) begin
      paddr = 8'($urandom); pwdata = $urandom; pwrite = 1'($urandom);
    end

    @(negedge clk);
    check({tag, ".c2_we"}, 32'(we), 32'd0);
    check({tag, ".c2_re"}, 32'(re), 32'd0);
    check({tag, ".c2_pready"}, 32'(pready), 32'd0);
    check({tag, ".c2_prdata_hold"}, prdata, last_prdata);
    rdata = rd;
    if (noise) begin
      psel = 1'b1; penable = 1'b0; paddr = 8'($urandom); pwdata = $urandom;
      reg_str = 1'($urandom); reg_opt = 1'($urandom);
    end

    @(negedge clk);
    check({tag, ".c3_pready"}, 32'(pready), 32'd1);
    check({tag, ".c3_prdata"}, prdata, exp_prd);
    check({tag, ".c3_pslverr"}, 32'(pslverr), 32'(ERR_EN && err));
    check({tag, ".c3_strobes"}, 32'(we | re), 32'd0);
    check({tag, ".c3_wdata"}, wdata, wd);
    psel = 1'b0; penable = 1'b0; rdata = $urandom;
    last_prdata = exp_prd;
    last_err    = ERR_EN && err;
  endtask

  initial begin
    bit          wr, str, opt;
    int          idx;
    logic [31:0] wd, rd;

    @(negedge clk);
    @(negedge clk);
    check("reset.we", 32'(we), 32'd0);
    check("reset.re", 32'(re), 32'd0);
    check("reset.wdata", wdata, 32'd0);
    check("reset.prdata", prdata, 32'd0);
    check("reset.pready", 32'(pready), 32'd0);
    check("reset.pslverr", 32'(pslverr), 32'd0);
    preset = 1'b0;

    xfer("wr_idx0", 8'h00, 1'b1, 32'h12, 1'b0, 1'b0, 32'h0, 1'b0);
    xfer("rd_ver", 8'h20, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000ABCD, 1'b0);
    xfer("wr_idx5_str", 8'h14, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    xfer("rd_unmapped", 8'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    xfer("wr_status", 8'h1C, 1'b1, 32'h5, 1'b0, 1'b0, 32'h0, 1'b0);
    xfer("wr_idx5_opt", 8'h17, 1'b1, 32'h77, 1'b0, 1'b1, 32'h0, 1'b0);
    xfer("wr_str_reg", 8'h04, 1'b1, 32'h1, 1'b1, 1'b1, 32'h0, 1'b0);
    xfer("wr_outcnt", 8'h10, 1'b1, 32'h44, 1'b1, 1'b1, 32'h0, 1'b0);
    xfer("wr_last_unmapped", 8'h24, 1'b1, 32'h99, 1'b0, 1'b0, 32'h0, 1'b0);
    xfer("b2b_wr", 8'h08, 1'b1, 32'hCAFE, 1'b0, 1'b0, 32'h0, 1'b0);
    xfer("b2b_rd", 8'h0C, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1234_5678, 1'b0);

    // Reset in WAIT of a read: transfer aborts, everything clears on the next edge.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = 8'h18; pwrite = 1'b0; pwdata = 32'hABAB;
    @(negedge clk);
    check("abort.c1_re", 32'(re), 32'h40);
    penable = 1'b1;
    @(negedge clk);
    preset = 1'b1; psel = 1'b0; penable = 1'b0; rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("abort.we", 32'(we), 32'd0);
    check("abort.re", 32'(re), 32'd0);
    check("abort.wdata", wdata, 32'd0);
    check("abort.prdata", prdata, 32'd0);
    check("abort.pready", 32'(pready), 32'd0);
    check("abort.pslverr", 32'(pslverr), 32'd0);
    preset = 1'b0;
    @(negedge clk);
    check("abort.no_pready", 32'(pready), 32'd0);
    last_prdata = '0;
    last_err    = 1'b0;
    xfer("post_abort_rd", 8'h18, 1'b0, 32'h3, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);

    for (int i = 0; i < 40; i++) begin
      idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 9));
      wr  = 1'($urandom);
      str = 1'($urandom);
      opt = 1'($urandom);
      wd  = $urandom;
      rd  = $urandom;
      xfer($sformatf("rand%0d", i), {6'(idx), 2'($urandom)}, wr, wd, str, opt, rd, 1'b1);
    end

    @(negedge clk);
    check("idle.pready", 32'(pready), 32'd0);
    check("idle.prdata_hold", prdata, last_prdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
